// File: rtl/pcs_transmit.sv
// pcs_transmit: 1000BASE-X PCS transmit, GMII bytes to 8b/10b code-groups with idle,
// delimiter, error propagation and even/odd slot alignment.
module pcs_transmit #(
  parameter int CG_WIDTH   = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  mr_main_reset,
  input  logic [DATA_WIDTH-1:0] txd,
  input  logic                  tx_en,
  input  logic                  tx_er,
  output logic [CG_WIDTH-1:0]   tx_code_group,
  output logic                  tx_even,
  output logic                  tx_disparity,
  output logic                  transmitting
);
  typedef enum logic [2:0] {IDLE_K, IDLE_D, START, DATA, END_T, END_R1, END_R2} state_t;
  state_t state, eff, nxt;
  logic [8:0]  sym;
  logic [10:0] code;
  // returns {running disparity after, abcdei, fghj}
  function automatic logic [10:0] encode(input logic k, input logic [7:0] d, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic u6, rd6, a7;
    x = d[4:0];
    y = d[7:5];
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = k ? 6'b001111 : 6'b001110;
      5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;  default: c6 = 6'b101011;
    endcase
    u6  = k || x inside {5'd0, 5'd1, 5'd2, 5'd4, 5'd8, 5'd15, 5'd16, 5'd23, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31};
    c6  = (rd && (u6 || x == 5'd7)) ? ~c6 : c6;
    rd6 = u6 ? ~rd : rd;
    a7  = y == 3'd7 && (rd6 ? x inside {5'd11, 5'd13, 5'd14} : x inside {5'd17, 5'd18, 5'd20});
    case (y)
      3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;  3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
      3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;  3'd6: c4 = 4'b0110;  default: c4 = a7 ? 4'b0111 : 4'b1110;
    endcase
    c4 = (rd6 && y inside {3'd0, 3'd3, 3'd4, 3'd7}) ? ~c4 : c4;
    // K28.5 and K.x.7 select their fghj from the disparity at the start of the code-group
    c4 = k ? ((x == 5'd28 ? 4'b1010 : 4'b1000) ^ {4{rd}}) : c4;
    return {k ? (x == 5'd28 ? ~rd : rd) : (y inside {3'd0, 3'd4, 3'd7} ? ~rd6 : rd6), c6, c4};
  endfunction
  always_comb begin
    eff  = (state == IDLE_K && tx_en) ? START : (state == DATA && !tx_en) ? END_T : state;
    sym  = eff == IDLE_K ? 9'h1BC :
           eff == IDLE_D ? {1'b0, tx_disparity ? 8'h50 : 8'hC5} :
           eff == START  ? 9'h1FB :
           eff == DATA   ? (tx_er ? 9'h1FE : {1'b0, txd}) :
           eff == END_T  ? 9'h1FD : 9'h1F7;
    code = encode(sym[8], sym[7:0], tx_disparity);
    nxt  = IDLE_K;
    case (eff)
      IDLE_K:  nxt = IDLE_D;
      IDLE_D:  nxt = tx_en ? START : IDLE_K;
      START:   nxt = tx_en ? DATA : END_T;
      DATA:    nxt = DATA;
      END_T:   nxt = END_R1;
      END_R1:  nxt = tx_even ? IDLE_K : END_R2;
      default: nxt = IDLE_K;
    endcase
  end
  always_ff @(posedge clk or posedge mr_main_reset)
    if (mr_main_reset) begin
      tx_code_group <= 10'b0011111010;
      tx_even       <= 1'b1;
      tx_disparity  <= 1'b1;
      transmitting  <= 1'b0;
      state         <= IDLE_D;
    end else begin
      {tx_disparity, tx_code_group} <= code;
      tx_even      <= ~tx_even;
      transmitting <= eff == START || eff == DATA;
      state        <= nxt;
    end
endmodule

// File: tb/tb_pcs_transmit.sv
// tb_pcs_transmit: directed checks of idle, framing, error propagation, encoder sweep and reset.
module tb_pcs_transmit;
  logic       clk = 1'b0, mr_main_reset = 1'b1, tx_en = 1'b0, tx_er = 1'b0;
  logic [7:0] txd = 8'h00;
  logic [9:0] tx_code_group;
  logic       tx_even, tx_disparity, transmitting;
  int         tests = 0, fails = 0;
  logic       mrd;
  logic [10:0] m;
  logic [5:0] t6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
                          6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
                          6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  always #5 clk = ~clk;
  pcs_transmit dut (
    .clk(clk), .mr_main_reset(mr_main_reset), .txd(txd), .tx_en(tx_en), .tx_er(tx_er),
    .tx_code_group(tx_code_group), .tx_even(tx_even), .tx_disparity(tx_disparity), .transmitting(transmitting)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic tick(input logic en, input logic er, input logic [7:0] d);
    tx_en = en;
    tx_er = er;
    txd   = d;
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input string tag, input logic en, input logic er, input logic [7:0] d,
                      input logic [9:0] cg, input logic ev, input logic rd, input logic tr);
    tick(en, er, d);
    check(tag, {3'b0, tx_even, tx_disparity, transmitting, tx_code_group}, {3'b0, ev, rd, tr, cg});
  endtask
  // data code-group model: sub-block disparity derived from ones count
  function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic r6, ro;
    x  = b[4:0];
    y  = b[7:5];
    c6 = t6[x];
    if (rd && ($countones(c6) != 3 || x == 5'd7)) c6 = ~c6;
    r6 = $countones(c6) > 3 ? 1'b1 : $countones(c6) < 3 ? 1'b0 : rd;
    c4 = t4[y];
    if (y == 3'd7 && (r6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14) : (x == 5'd17 || x == 5'd18 || x == 5'd20)))
      c4 = 4'b0111;
    if (r6 && ($countones(c4) != 2 || y == 3'd3)) c4 = ~c4;
    ro = $countones(c4) > 2 ? 1'b1 : $countones(c4) < 2 ? 1'b0 : r6;
    return {ro, c6, c4};
  endfunction
  initial begin
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("reset", {3'b0, tx_even, tx_disparity, transmitting, tx_code_group}, {3'b0, 3'b110, 10'b0011111010});
    mr_main_reset = 1'b0;
    slot("idle1", 0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("idle2", 0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("idle3", 0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("idle4", 0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("idle5", 0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("a_s",   1, 0, 8'h55, 10'b1101101000, 1, 0, 1);
    slot("a_d1",  1, 0, 8'hD5, 10'b1010100110, 0, 0, 1);
    slot("a_d2",  1, 0, 8'h00, 10'b1001110100, 1, 0, 1);
    slot("a_t",   0, 0, 8'h00, 10'b1011101000, 0, 0, 0);
    slot("a_r1",  1, 0, 8'h00, 10'b1110101000, 1, 0, 0);
    slot("a_r2",  1, 0, 8'h00, 10'b1110101000, 0, 0, 0);
    slot("a_k",   0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("a_i",   0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("a_k2",  0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("b_i",   1, 0, 8'h55, 10'b1001000101, 0, 0, 0);
    slot("b_s",   1, 0, 8'hD5, 10'b1101101000, 1, 0, 1);
    slot("b_d",   1, 0, 8'h00, 10'b1001110100, 0, 0, 1);
    slot("b_t",   0, 0, 8'h00, 10'b1011101000, 1, 0, 0);
    slot("b_r",   0, 0, 8'h00, 10'b1110101000, 0, 0, 0);
    slot("b_k",   0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("b_i2",  0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("c_s",   1, 0, 8'hAA, 10'b1101101000, 1, 0, 1);
    slot("c_d1",  1, 0, 8'h55, 10'b1010100101, 0, 0, 1);
    slot("c_v",   1, 1, 8'h55, 10'b0111101000, 1, 0, 1);
    slot("c_d3",  1, 0, 8'h03, 10'b1100011011, 0, 1, 1);
    slot("c_t",   0, 0, 8'h00, 10'b0100010111, 1, 1, 0);
    slot("c_r",   0, 1, 8'h00, 10'b0001010111, 0, 1, 0);
    slot("c_kp",  0, 1, 8'h00, 10'b1100000101, 1, 0, 0);
    slot("c_i1",  0, 1, 8'h00, 10'b1010010110, 0, 0, 0);
    slot("c_k",   0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("c_i2",  0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("sw_s",  1, 0, 8'h00, 10'b1101101000, 1, 0, 1);
    mrd = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 256; b++) begin
        if (mrd != r[0]) begin
          m = ref_enc(8'h03, mrd);
          tick(1, 0, 8'h03);
          check("flip", {5'b0, tx_disparity, tx_code_group}, {5'b0, m});
          mrd = m[10];
        end
        m = ref_enc(b[7:0], mrd);
        tick(1, 0, b[7:0]);
        check($sformatf("enc_%02h_rd%0d", b, r), {5'b0, tx_disparity, tx_code_group}, {5'b0, m});
        mrd = m[10];
        if (b == 8'hF1)
          check($sformatf("d17_7_rd%0d", r), {6'b0, tx_code_group}, {6'b0, r[0] ? 10'b1000110001 : 10'b1000110111});
      end
    for (int i = 0; i < 6; i++) tick(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1, 0, 8'h5A);
    check("pre_rst", {15'b0, transmitting}, 16'd1);
    #2 mr_main_reset = 1'b1;
    #1;
    check("rst_async", {3'b0, tx_even, tx_disparity, transmitting, tx_code_group}, {3'b0, 3'b110, 10'b0011111010});
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    check("rst_hold", {3'b0, tx_even, tx_disparity, transmitting, tx_code_group}, {3'b0, 3'b110, 10'b0011111010});
    mr_main_reset = 1'b0;
    slot("post1", 0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("post2", 0, 0, 8'h00, 10'b0011111010, 1, 1, 0);
    slot("post3", 0, 0, 8'h00, 10'b1001000101, 0, 0, 0);
    slot("post_s", 1, 0, 8'h00, 10'b1101101000, 1, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
